// File: rtl/cla8_addsub_pipe_if.sv
// rtl/cla8_addsub_pipe_if.sv - operand/result handshake bundle for the CLA add/sub pipe
interface cla8_addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    // Operand producer / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    // Adder pipeline side
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/cla8_addsub_pipe.sv
// rtl/cla8_addsub_pipe.sv - two-stage carry-lookahead adder/subtractor with valid/ready
module cla8_addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cla8_addsub_pipe_if.slave bus
);
    localparam int NGRP = WIDTH / 4;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_bx;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_cout;
    logic             s2_ovf;
    logic             s2_zero;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;
    logic [3:0]       gg;
    logic [3:0]       pg;
    logic             gc;

    // A stage may load whenever it is empty or its content moves on this cycle,
    // so bubbles collapse even while the consumer stalls.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // Subtract is A + ~B + 1: B inverted here, the +1 enters as carry-in.
    assign bx = bus.in_b ^ {WIDTH{bus.in_sub}};

    // Stage 1: condition B and form bitwise generate/propagate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_bx    <= '0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_cin   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            // Data only loads on a real beat so idle-bus X never enters the pipe
            if (bus.in_valid) begin
                s1_a   <= bus.in_a;
                s1_bx  <= bx;
                s1_g   <= bus.in_a & bx;
                s1_p   <= bus.in_a ^ bx;
                s1_cin <= bus.in_sub;
            end
        end
    end

    // Carries: full lookahead inside each 4-bit group, group carry ripples to the next
    always_comb begin
        carry    = '0;
        gg       = '0;
        pg       = '0;
        gc       = s1_cin;
        carry[0] = s1_cin;
        for (int grp = 0; grp < NGRP; grp++) begin
            gg = s1_g[4*grp +: 4];
            pg = s1_p[4*grp +: 4];
            carry[4*grp+1] = gg[0] | (pg[0] & gc);
            carry[4*grp+2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & gc);
            carry[4*grp+3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                           | (pg[2] & pg[1] & pg[0] & gc);
            carry[4*grp+4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                           | (pg[3] & pg[2] & pg[1] & gg[0])
                           | (pg[3] & pg[2] & pg[1] & pg[0] & gc);
            gc = carry[4*grp+4];
        end
        sum_c = s1_p ^ carry[WIDTH-1:0];
        ovf_c = (s1_a[WIDTH-1] == s1_bx[WIDTH-1]) && (sum_c[WIDTH-1] != s1_a[WIDTH-1]);
    end

    // Stage 2: register sum and flags; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_cout  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_zero  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= sum_c;
                s2_cout <= carry[WIDTH];
                s2_ovf  <= ovf_c;
                s2_zero <= (sum_c == '0);
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = s2_sum;
    assign bus.out_cout  = s2_cout;
    assign bus.out_ovf   = s2_ovf;
    assign bus.out_zero  = s2_zero;
endmodule

// File: tb/tb_cla8_addsub_pipe.sv
// tb/tb_cla8_addsub_pipe.sv - self-checking bench for cla8_addsub_pipe at WIDTH 8 and 16
module tb_cla8_addsub_pipe;
    typedef struct {
        int sum;
        bit cout;
        bit ovf;
        bit zero;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   dlv [2];
    exp_t q [2][$];

    always #5 clk = ~clk;

    cla8_addsub_pipe_if #(.WIDTH(8))  if8  ();
    cla8_addsub_pipe_if #(.WIDTH(16)) if16 ();

    cla8_addsub_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    cla8_addsub_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned sum, signed range test, borrow as A >= B
    function automatic exp_t model(int w, int a, int b, bit sub);
        exp_t e;
        int   mask = (1 << w) - 1;
        int   half = 1 << (w - 1);
        int   sa = (a >= half) ? a - (1 << w) : a;
        int   sb = (b >= half) ? b - (1 << w) : b;
        int   sr = sub ? sa - sb : sa + sb;
        int   u  = sub ? a - b : a + b;
        e.sum  = u & mask;
        e.cout = sub ? (a >= b) : (u > mask);
        e.ovf  = (sr >= half) || (sr < -half);
        e.zero = (e.sum == 0);
        e.t    = 0;
        return e;
    endfunction

    task automatic mon(int k, int w, logic iv, logic ir, logic ov, logic ordy,
                       logic [15:0] a, logic [15:0] b, logic sub,
                       logic [15:0] s, logic co, logic of, logic z);
        exp_t  e;
        string p = (k == 0) ? "w8" : "w16";
        check({p, "_in_ready"}, ir, (q[k].size() < 2) || ordy);
        check({p, "_out_valid"}, ov, (q[k].size() > 0) && (cyc - q[k][0].t >= 2));
        if (ov === 1'b1 && q[k].size() > 0) begin
            e = q[k][0];
            check({p, "_sum"},  s,  e.sum);
            check({p, "_cout"}, co, e.cout);
            check({p, "_ovf"},  of, e.ovf);
            check({p, "_zero"}, z,  e.zero);
            if (ordy) begin
                void'(q[k].pop_front());
                dlv[k]++;
            end
        end
        if (iv && ir) begin
            e   = model(w, int'(a), int'(b), sub);
            e.t = cyc;
            q[k].push_back(e);
        end
    endtask

    // Compare process: handshake decisions are stable mid-cycle, ahead of the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
        end else begin
            mon(0, 8, if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready,
                16'(if8.in_a), 16'(if8.in_b), if8.in_sub,
                16'(if8.out_sum), if8.out_cout, if8.out_ovf, if8.out_zero);
            mon(1, 16, if16.in_valid, if16.in_ready, if16.out_valid, if16.out_ready,
                if16.in_a, if16.in_b, if16.in_sub,
                if16.out_sum, if16.out_cout, if16.out_ovf, if16.out_zero);
        end
        cyc++;
    end

    task automatic run_vec(string nm, logic [7:0] a, logic [7:0] b, logic sub,
                           logic [7:0] es, logic ec, logic eo, logic ez);
        if8.in_a = a; if8.in_b = b; if8.in_sub = sub;
        if8.in_valid = 1'b1; if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        check({nm, "_valid"}, if8.out_valid, 1'b1);
        check({nm, "_sum"},   if8.out_sum,   es);
        check({nm, "_cout"},  if8.out_cout,  ec);
        check({nm, "_ovf"},   if8.out_ovf,   eo);
        check({nm, "_zero"},  if8.out_zero,  ez);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   n, start_dlv, sent8, sent16;
        bit   acc, acc8, acc16;

        dlv[0] = 0; dlv[1] = 0;
        if8.in_valid = 1'b0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_sub = 1'b0;  if8.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_sub = 1'b0; if16.out_ready = 1'b1;

        e = model(8, 'h7F, 'h01, 1'b0);
        check("model_add_ovf", {e.sum[7:0], 1'(e.cout), 1'(e.ovf), 1'(e.zero)}, {8'h80, 3'b010});
        e = model(8, 'h03, 'h05, 1'b1);
        check("model_sub_borrow", {e.sum[7:0], 1'(e.cout), 1'(e.ovf), 1'(e.zero)}, {8'hFE, 3'b000});
        e = model(16, 'h8000, 'h0001, 1'b1);
        check("model_sub16_ovf", {e.sum[15:0], 1'(e.cout), 1'(e.ovf), 1'(e.zero)}, {16'h7FFF, 3'b110});

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", if8.out_valid, 1'b0);
        check("reset_out_flags", {if8.out_sum, if8.out_cout, if8.out_ovf, if8.out_zero}, 11'h0);
        check("reset_out16", {if16.out_valid, if16.out_sum}, 17'h0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", if8.in_ready, 1'b1);
        @(posedge clk); #1;

        run_vec("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_vec("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_vec("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_vec("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_vec("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Backpressure: consumer stalls for the first three cycles of a 4-beat stream
        start_dlv = dlv[0];
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if8.in_valid = 1'b1;
            if8.in_a = 8'(8'h10 * n + 8'h0F);
            if8.in_b = 8'(n + 3);
            if8.in_sub = n[0];
            if8.out_ready = (c >= 3);
            @(negedge clk);
            acc = if8.in_valid && if8.in_ready;
            if (c == 2) check("bp_in_ready_full", if8.in_ready, 1'b0);
            @(posedge clk); #1;
            if (acc) n++;
        end
        check("bp_accepted", n, 4);
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_delivered", dlv[0] - start_dlv, 4);

        // Reset with two beats in flight
        if8.out_ready = 1'b0;
        if8.in_valid = 1'b1; if8.in_a = 8'h11; if8.in_b = 8'h22; if8.in_sub = 1'b0;
        @(posedge clk); #1;
        if8.in_a = 8'h33;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        check("rst_pre_valid", if8.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", if8.out_valid, 1'b0);
        check("rst_async_sum", if8.out_sum, 8'h00);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", if8.in_ready, 1'b1);
        check("rst_release_valid", if8.out_valid, 1'b0);
        if8.out_ready = 1'b1;
        @(posedge clk); #1;

        // Random traffic on both widths; idle 8-bit operands are driven to X
        sent8 = 0; sent16 = 0; acc8 = 1'b0; acc16 = 1'b0;
        for (int c = 0; c < 40000 && (sent8 < 10000 || sent16 < 10000); c++) begin
            if (!if8.in_valid || acc8) begin
                if8.in_valid = (sent8 < 10000) && ($urandom_range(0, 3) != 0);
                if (if8.in_valid) begin
                    if8.in_a = 8'($urandom); if8.in_b = 8'($urandom); if8.in_sub = 1'($urandom);
                end else begin
                    if8.in_a = 'x; if8.in_b = 'x; if8.in_sub = 1'bx;
                end
            end
            if (!if16.in_valid || acc16) begin
                if16.in_valid = (sent16 < 10000) && ($urandom_range(0, 3) != 0);
                if16.in_a = 16'($urandom); if16.in_b = 16'($urandom); if16.in_sub = 1'($urandom);
            end
            if8.out_ready  = ($urandom_range(0, 3) != 0);
            if16.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc8  = if8.in_valid && if8.in_ready;
            acc16 = if16.in_valid && if16.in_ready;
            @(posedge clk); #1;
            sent8  += int'(acc8);
            sent16 += int'(acc16);
        end
        check("rand_sent8", sent8, 10000);
        check("rand_sent16", sent16, 10000);
        if8.in_valid = 1'b0;  if8.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drain8", q[0].size(), 0);
        check("rand_drain16", q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
